// File: rtl/huffman_pkg.sv
// Shared types and constants for the Huffman decoder slice.
// Optional symbol counters are enabled with `define HUFFDEC_CNT_EN.
package huffman_pkg;

  localparam int NSYM = 6;
  localparam int CW   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    ERR    = 2'd2
  } dec_state_t;

  typedef logic [2:0] sym_t;

endpackage

// File: rtl/huffman_match.sv
// Combinational codeword matcher: compares the candidate shift register and
// length mask against the six loaded table entries, lowest index wins.
module huffman_match
  import huffman_pkg::*;
(
  input  logic [CW-1:0] i_shreg_n,
  input  logic [CW-1:0] i_lmask_n,
  input  logic [CW-1:0] i_hc1,
  input  logic [CW-1:0] i_hc2,
  input  logic [CW-1:0] i_hc3,
  input  logic [CW-1:0] i_hc4,
  input  logic [CW-1:0] i_hc5,
  input  logic [CW-1:0] i_hc6,
  input  logic [CW-1:0] i_m1,
  input  logic [CW-1:0] i_m2,
  input  logic [CW-1:0] i_m3,
  input  logic [CW-1:0] i_m4,
  input  logic [CW-1:0] i_m5,
  input  logic [CW-1:0] i_m6,
  output logic          o_hit,
  output sym_t          o_idx
);

  logic [CW-1:0] w_hc [NSYM];
  logic [CW-1:0] w_m  [NSYM];

  assign w_hc[0] = i_hc1;
  assign w_hc[1] = i_hc2;
  assign w_hc[2] = i_hc3;
  assign w_hc[3] = i_hc4;
  assign w_hc[4] = i_hc5;
  assign w_hc[5] = i_hc6;

  assign w_m[0] = i_m1;
  assign w_m[1] = i_m2;
  assign w_m[2] = i_m3;
  assign w_m[3] = i_m4;
  assign w_m[4] = i_m5;
  assign w_m[5] = i_m6;

  // Scanning from the highest index down lets the lowest matching index overwrite.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = NSYM - 1; i >= 0; i--) begin
      if ((w_m[i] != '0) && (i_lmask_n == w_m[i]) && (i_shreg_n == w_hc[i])) begin
        o_hit = 1'b1;
        o_idx = sym_t'(i + 1);
      end
    end
  end

endmodule

// File: rtl/huffman_decoder.sv
// Serial MSB-first Huffman decoder with ready/valid on bits and symbols.
// Define HUFFDEC_CNT_EN to add saturating per-symbol match counters DCNT1..DCNT6.
module huffman_decoder
  import huffman_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          code_valid,
  input  logic [CW-1:0] HC1,
  input  logic [CW-1:0] HC2,
  input  logic [CW-1:0] HC3,
  input  logic [CW-1:0] HC4,
  input  logic [CW-1:0] HC5,
  input  logic [CW-1:0] HC6,
  input  logic [CW-1:0] M1,
  input  logic [CW-1:0] M2,
  input  logic [CW-1:0] M3,
  input  logic [CW-1:0] M4,
  input  logic [CW-1:0] M5,
  input  logic [CW-1:0] M6,
  input  logic          bit_valid,
  input  logic          bit_in,
  output logic          bit_ready,
  output logic          sym_valid,
  output sym_t          sym_out,
  input  logic          sym_ready,
  output logic          err
`ifdef HUFFDEC_CNT_EN
  ,
  output logic [7:0]    DCNT1,
  output logic [7:0]    DCNT2,
  output logic [7:0]    DCNT3,
  output logic [7:0]    DCNT4,
  output logic [7:0]    DCNT5,
  output logic [7:0]    DCNT6
`endif
);

  dec_state_t    r_state;
  logic [CW-1:0] r_hc [NSYM];
  logic [CW-1:0] r_m  [NSYM];
  // Only seven bits are ever kept: an eighth unmatched bit always lands in ERR.
  logic [CW-2:0] r_shreg;
  logic [CW-2:0] r_lmask;
  sym_t          r_sym_out;
  logic          r_sym_valid;
  logic          r_err;

  logic          w_bit_ready;
  logic          w_accept;
  logic [CW-1:0] w_shreg_n;
  logic [CW-1:0] w_lmask_n;
  logic          w_hit;
  sym_t          w_idx;

  assign w_bit_ready = (r_state == DECODE) && !code_valid && (!r_sym_valid || sym_ready);
  assign w_accept    = bit_valid && w_bit_ready;
  assign w_shreg_n   = {r_shreg, bit_in};
  assign w_lmask_n   = {r_lmask, 1'b1};

  huffman_match u_match (
    .i_shreg_n (w_shreg_n),
    .i_lmask_n (w_lmask_n),
    .i_hc1     (r_hc[0]),
    .i_hc2     (r_hc[1]),
    .i_hc3     (r_hc[2]),
    .i_hc4     (r_hc[3]),
    .i_hc5     (r_hc[4]),
    .i_hc6     (r_hc[5]),
    .i_m1      (r_m[0]),
    .i_m2      (r_m[1]),
    .i_m3      (r_m[2]),
    .i_m4      (r_m[3]),
    .i_m5      (r_m[4]),
    .i_m6      (r_m[5]),
    .o_hit     (w_hit),
    .o_idx     (w_idx)
  );

  // A table load overrides everything else, including a bit offered the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      for (int i = 0; i < NSYM; i++) begin
        r_hc[i] <= '0;
        r_m[i]  <= '0;
      end
      r_shreg     <= '0;
      r_lmask     <= '0;
      r_sym_out   <= '0;
      r_sym_valid <= 1'b0;
      r_err       <= 1'b0;
    end else if (code_valid) begin
      r_hc[0]     <= HC1;
      r_hc[1]     <= HC2;
      r_hc[2]     <= HC3;
      r_hc[3]     <= HC4;
      r_hc[4]     <= HC5;
      r_hc[5]     <= HC6;
      r_m[0]      <= M1;
      r_m[1]      <= M2;
      r_m[2]      <= M3;
      r_m[3]      <= M4;
      r_m[4]      <= M5;
      r_m[5]      <= M6;
      r_shreg     <= '0;
      r_lmask     <= '0;
      r_sym_valid <= 1'b0;
      r_err       <= 1'b0;
      r_state     <= DECODE;
    end else begin
      case (r_state)
        DECODE: begin
          if (r_sym_valid && sym_ready) begin
            r_sym_valid <= 1'b0;
          end
          if (w_accept) begin
            if (w_hit) begin
              r_sym_out   <= w_idx;
              r_sym_valid <= 1'b1;
              r_shreg     <= '0;
              r_lmask     <= '0;
            end else if (w_lmask_n == '1) begin
              r_state <= ERR;
              r_err   <= 1'b1;
              r_shreg <= '0;
              r_lmask <= '0;
            end else begin
              r_shreg <= w_shreg_n[CW-2:0];
              r_lmask <= w_lmask_n[CW-2:0];
            end
          end
        end
        ERR: begin
          r_err <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bit_ready = w_bit_ready;
  assign sym_valid = r_sym_valid;
  assign sym_out   = r_sym_out;
  assign err       = r_err;

`ifdef HUFFDEC_CNT_EN
  logic [7:0] r_dcnt [NSYM];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NSYM; i++) begin
        r_dcnt[i] <= '0;
      end
    end else if (code_valid) begin
      for (int i = 0; i < NSYM; i++) begin
        r_dcnt[i] <= '0;
      end
    end else if (w_accept && w_hit) begin
      for (int i = 0; i < NSYM; i++) begin
        if ((w_idx == sym_t'(i + 1)) && (r_dcnt[i] != 8'hFF)) begin
          r_dcnt[i] <= r_dcnt[i] + 8'd1;
        end
      end
    end
  end

  assign DCNT1 = r_dcnt[0];
  assign DCNT2 = r_dcnt[1];
  assign DCNT3 = r_dcnt[2];
  assign DCNT4 = r_dcnt[3];
  assign DCNT5 = r_dcnt[4];
  assign DCNT6 = r_dcnt[5];
`endif

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed self-checking bench for huffman_decoder using a unary-style code table.
// Counter outputs are checked as well when HUFFDEC_CNT_EN is defined.
module tb_huffman_decoder;
  import huffman_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          code_valid = 1'b0;
  logic [CW-1:0] HC1 = '0, HC2 = '0, HC3 = '0, HC4 = '0, HC5 = '0, HC6 = '0;
  logic [CW-1:0] M1 = '0, M2 = '0, M3 = '0, M4 = '0, M5 = '0, M6 = '0;
  logic          bit_valid = 1'b0;
  logic          bit_in = 1'b0;
  logic          bit_ready;
  logic          sym_valid;
  sym_t          sym_out;
  logic          sym_ready = 1'b0;
  logic          err;
`ifdef HUFFDEC_CNT_EN
  logic [7:0]    DCNT1, DCNT2, DCNT3, DCNT4, DCNT5, DCNT6;
`endif

  int nCompared = 0;
  int nMismatched = 0;

  // Bits sent in the first sequence, MSB first, with expected valid flags and held symbol.
  logic [7:0] t1Bits  = 8'b10100000;
  logic [7:0] t1Valid = 8'b10100001;
  sym_t       t1Sym [8] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd6};

  always #5 clk = ~clk;

  huffman_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .HC1        (HC1),
    .HC2        (HC2),
    .HC3        (HC3),
    .HC4        (HC4),
    .HC5        (HC5),
    .HC6        (HC6),
    .M1         (M1),
    .M2         (M2),
    .M3         (M3),
    .M4         (M4),
    .M5         (M5),
    .M6         (M6),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .bit_ready  (bit_ready),
    .sym_valid  (sym_valid),
    .sym_out    (sym_out),
    .sym_ready  (sym_ready),
    .err        (err)
`ifdef HUFFDEC_CNT_EN
    ,
    .DCNT1      (DCNT1),
    .DCNT2      (DCNT2),
    .DCNT3      (DCNT3),
    .DCNT4      (DCNT4),
    .DCNT5      (DCNT5),
    .DCNT6      (DCNT6)
`endif
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic bv, input logic b, input logic sr);
    bit_valid = bv;
    bit_in    = b;
    sym_ready = sr;
    #1;
  endtask

  // Drives the table for one cycle with code_valid; bit_ready must be low during the load.
  task automatic loadTable(input logic [7:0] m6);
    HC1 = 8'h01; M1 = 8'h01;
    HC2 = 8'h01; M2 = 8'h03;
    HC3 = 8'h01; M3 = 8'h07;
    HC4 = 8'h01; M4 = 8'h0F;
    HC5 = 8'h01; M5 = 8'h1F;
    HC6 = 8'h00; M6 = m6;
    code_valid = 1'b1;
    #1;
    checkOutput("load_bit_ready_low", {7'd0, bit_ready}, 8'd0);
    tick();
    code_valid = 1'b0;
    #1;
  endtask

  initial begin
    $display("[TB] huffman_decoder directed test");

    // Reset state
    tick();
    checkOutput("rst_sym_valid", {7'd0, sym_valid}, 8'd0);
    checkOutput("rst_sym_out", {5'd0, sym_out}, 8'd0);
    checkOutput("rst_err", {7'd0, err}, 8'd0);
    checkOutput("rst_bit_ready", {7'd0, bit_ready}, 8'd0);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("idle_bit_ready", {7'd0, bit_ready}, 8'd0);
    tick();
    checkOutput("idle_no_sym", {7'd0, sym_valid}, 8'd0);

    // Sequence 1: 1,0,1,0,0,0,0,0 -> symbols 1, 2, 6
    applyStimulus(1'b0, 1'b0, 1'b1);
    loadTable(8'h1F);
    checkOutput("t1_loaded_ready", {7'd0, bit_ready}, 8'd1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, t1Bits[7-i], 1'b1);
      checkOutput("t1_bit_ready", {7'd0, bit_ready}, 8'd1);
      tick();
      checkOutput("t1_sym_valid", {7'd0, sym_valid}, {7'd0, t1Valid[7-i]});
      checkOutput("t1_sym_out", {5'd0, sym_out}, {5'd0, t1Sym[i]});
    end
    checkOutput("t1_err", {7'd0, err}, 8'd0);

    // Sequence 2: eight 1s back-to-back -> eight consecutive symbol 1
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("t2_bit_ready", {7'd0, bit_ready}, 8'd1);
      tick();
      checkOutput("t2_sym_valid", {7'd0, sym_valid}, 8'd1);
      checkOutput("t2_sym_out", {5'd0, sym_out}, 8'd1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("t2_drain", {7'd0, sym_valid}, 8'd0);

    // Sequence 3: "001" under backpressure, then release
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("t3_sym_valid", {7'd0, sym_valid}, 8'd1);
    checkOutput("t3_sym_out", {5'd0, sym_out}, 8'd3);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("t3_stall_ready", {7'd0, bit_ready}, 8'd0);
      tick();
      checkOutput("t3_stall_valid", {7'd0, sym_valid}, 8'd1);
      checkOutput("t3_stall_sym", {5'd0, sym_out}, 8'd3);
    end
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t3_release_ready", {7'd0, bit_ready}, 8'd1);
    tick();
    checkOutput("t3_next_valid", {7'd0, sym_valid}, 8'd1);
    checkOutput("t3_next_sym", {5'd0, sym_out}, 8'd1);

    // Sequence 4: M6=0, eight 0s -> error, then reload clears it
    applyStimulus(1'b0, 1'b0, 1'b1);
    loadTable(8'h00);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("t4_bit_ready", {7'd0, bit_ready}, 8'd1);
      checkOutput("t4_err_before", {7'd0, err}, 8'd0);
      tick();
      checkOutput("t4_no_sym", {7'd0, sym_valid}, 8'd0);
    end
    checkOutput("t4_err_set", {7'd0, err}, 8'd1);
    checkOutput("t4_err_ready", {7'd0, bit_ready}, 8'd0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("t4_err_sticky", {7'd0, err}, 8'd1);
    checkOutput("t4_err_nosym", {7'd0, sym_valid}, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    loadTable(8'h1F);
    checkOutput("t4_err_cleared", {7'd0, err}, 8'd0);
    checkOutput("t4_decode_ready", {7'd0, bit_ready}, 8'd1);

    // Sequence 5: "00" then reload with a coincident bit, then "1"
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("t5_partial", {7'd0, sym_valid}, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    loadTable(8'h1F);
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("t5_valid", {7'd0, sym_valid}, 8'd1);
    checkOutput("t5_sym", {5'd0, sym_out}, 8'd1);
`ifdef HUFFDEC_CNT_EN
    checkOutput("t5_dcnt1", DCNT1, 8'd1);
    checkOutput("t5_dcnt3", DCNT3, 8'd0);
`endif

    // Reset asserted mid-codeword
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst2_sym_valid", {7'd0, sym_valid}, 8'd0);
    checkOutput("rst2_sym_out", {5'd0, sym_out}, 8'd0);
    checkOutput("rst2_bit_ready", {7'd0, bit_ready}, 8'd0);
    tick();
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("rst2_idle_ready", {7'd0, bit_ready}, 8'd0);
    tick();
    checkOutput("rst2_idle_nosym", {7'd0, sym_valid}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
